// File: rtl/gbp_ghr_ckpt_if.sv
// Bundle between the fetch/resolve pipeline and the global-history front end.
// The master side drives lookups, predictions and resolutions. The slave side returns the index, history and updates.
interface gbp_ghr_ckpt_if #(
  parameter int VLEN       = 64,
  parameter int INDEX_BITS = 8,
  parameter int HIST_LEN   = 8
);
  logic                  flush_bp_i;
  logic                  debug_mode_i;
  logic [VLEN-1:0]       vpc_i;
  logic [INDEX_BITS-1:0] index_o;
  logic [HIST_LEN-1:0]   ghr_o;
  logic                  spec_valid_i;
  logic                  spec_taken_i;
  logic                  spec_ready_o;
  logic                  resolve_valid_i;
  logic                  resolve_taken_i;
  logic                  resolve_mispredict_i;
  logic                  pipe_flush_i;
  logic                  upd_valid_o;
  logic [INDEX_BITS-1:0] upd_index_o;
  logic                  upd_taken_o;

  modport master (
    output flush_bp_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
           resolve_valid_i, resolve_taken_i, resolve_mispredict_i, pipe_flush_i,
    input  index_o, ghr_o, spec_ready_o, upd_valid_o, upd_index_o, upd_taken_o
  );

  modport slave (
    input  flush_bp_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
           resolve_valid_i, resolve_taken_i, resolve_mispredict_i, pipe_flush_i,
    output index_o, ghr_o, spec_ready_o, upd_valid_o, upd_index_o, upd_taken_o
  );
endinterface

// File: rtl/gbp_ghr_ckpt.sv
// Speculative global history with an in-order checkpoint FIFO for repair on mispredict,
// plus the registered resolved-branch update stream feeding the gbp update port.
module gbp_ghr_ckpt #(
  parameter int VLEN       = 64,
  parameter int INDEX_BITS = 8,
  parameter int HIST_LEN   = 8,
  parameter int NR_CKPT    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  gbp_ghr_ckpt_if.slave bus
);
  localparam int PTR_W = $clog2(NR_CKPT);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(NR_CKPT);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [HIST_LEN-1:0]   spec_ghr_q, spec_ghr_d;
  logic [HIST_LEN-1:0]   arch_ghr_q, arch_ghr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        cnt_q, cnt_d;
  logic [HIST_LEN-1:0]   snap_q [NR_CKPT];
  logic [HIST_LEN-1:0]   snap_d [NR_CKPT];
  logic [INDEX_BITS-1:0] idx_q  [NR_CKPT];
  logic [INDEX_BITS-1:0] idx_d  [NR_CKPT];
  logic                  upd_valid_q, upd_valid_d;
  logic [INDEX_BITS-1:0] upd_index_q, upd_index_d;
  logic                  upd_taken_q, upd_taken_d;

  logic [INDEX_BITS-1:0] index;
  logic [HIST_LEN-1:0]   head_snap;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  full, empty, push, pop;
  logic                  unused_vpc;

  function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] ghr,
                                                   input logic b);
    return {ghr[HIST_LEN-2:0], b};
  endfunction

  assign index      = bus.vpc_i[INDEX_BITS:1] ^ INDEX_BITS'(spec_ghr_q);
  assign unused_vpc = ^{bus.vpc_i[VLEN-1:INDEX_BITS+1], bus.vpc_i[0]};
  assign head_snap  = snap_q[rd_ptr_q];
  assign head_idx   = idx_q[rd_ptr_q];
  assign full       = (cnt_q == CNT_FULL);
  assign empty      = (cnt_q == '0);
  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot for a push.
  assign push       = bus.spec_valid_i & ~full & ~bus.debug_mode_i;
  assign pop        = bus.resolve_valid_i & ~empty;

  assign bus.index_o      = index;
  assign bus.ghr_o        = spec_ghr_q;
  assign bus.spec_ready_o = ~full;
  assign bus.upd_valid_o  = upd_valid_q;
  assign bus.upd_index_o  = upd_index_q;
  assign bus.upd_taken_o  = upd_taken_q;

  always_comb begin
    spec_ghr_d  = spec_ghr_q;
    arch_ghr_d  = arch_ghr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    upd_valid_d = 1'b0;
    upd_index_d = upd_index_q;
    upd_taken_d = upd_taken_q;

    // Commit the head first; the flush paths below build on the updated arch history.
    if (pop) begin
      arch_ghr_d  = shift_in(head_snap, bus.resolve_taken_i);
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      cnt_d       = cnt_q - CNT_ONE;
      upd_valid_d = 1'b1;
      upd_index_d = head_idx;
      upd_taken_d = bus.resolve_taken_i;
    end

    if (bus.pipe_flush_i) begin
      spec_ghr_d = arch_ghr_d;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
    end else if (pop && bus.resolve_mispredict_i) begin
      spec_ghr_d = shift_in(head_snap, bus.resolve_taken_i);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
    end else if (push) begin
      snap_d[wr_ptr_q] = spec_ghr_q;
      idx_d[wr_ptr_q]  = index;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
      cnt_d            = cnt_d + CNT_ONE;
      spec_ghr_d       = shift_in(spec_ghr_q, bus.spec_taken_i);
    end

    if (bus.flush_bp_i) begin
      spec_ghr_d  = '0;
      arch_ghr_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      upd_valid_d = 1'b0;
      upd_index_d = '0;
      upd_taken_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      spec_ghr_q  <= spec_ghr_d;
      arch_ghr_q  <= arch_ghr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      upd_valid_q <= upd_valid_d;
      upd_index_q <= upd_index_d;
      upd_taken_q <= upd_taken_d;
    end
  end

  // Checkpoint storage carries data only; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    snap_q <= snap_d;
    idx_q  <= idx_d;
  end

  a_resolve_nonempty: assert property (@(posedge clk_i) disable iff (rst_i || bus.flush_bp_i)
    bus.resolve_valid_i |-> !empty);
endmodule

// File: tb/tb_gbp_ghr_ckpt.sv
// Bench for gbp_ghr_ckpt: directed scenarios plus randomized traffic against a queue-based model.
module tb_gbp_ghr_ckpt;
  localparam int VLEN = 64, IB = 8, HL = 8, NC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gbp_ghr_ckpt_if #(.VLEN(VLEN), .INDEX_BITS(IB), .HIST_LEN(HL)) bus ();
  gbp_ghr_ckpt #(.VLEN(VLEN), .INDEX_BITS(IB), .HIST_LEN(HL), .NR_CKPT(NC))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_vec = 0, n_err = 0;
  int m_spec, m_arch, m_ui, m_ut;
  bit m_uv;
  int m_snap[$];
  int m_idx[$];

  function automatic int exp_index();
    return int'((bus.vpc_i >> 1) & 64'hFF) ^ m_spec;
  endfunction

  task automatic model_step();
    int  idx_now, snap;
    bit  pop, push, full;
    if (rst || bus.flush_bp_i) begin
      m_spec = 0; m_arch = 0; m_uv = 0; m_ui = 0; m_ut = 0;
      m_snap.delete(); m_idx.delete();
      return;
    end
    idx_now = exp_index();
    full = (m_snap.size() == NC);
    pop  = bus.resolve_valid_i && (m_snap.size() > 0);
    push = bus.spec_valid_i && !full && !bus.debug_mode_i;
    snap = 0;
    m_uv = pop;
    if (pop) begin
      snap   = m_snap.pop_front();
      m_ui   = m_idx.pop_front();
      m_ut   = int'(bus.resolve_taken_i);
      m_arch = ((snap << 1) | m_ut) & 255;
    end
    if (bus.pipe_flush_i) begin
      m_spec = m_arch;
      m_snap.delete(); m_idx.delete();
    end else if (pop && bus.resolve_mispredict_i) begin
      m_spec = ((snap << 1) | m_ut) & 255;
      m_snap.delete(); m_idx.delete();
    end else if (push) begin
      m_snap.push_back(m_spec);
      m_idx.push_back(idx_now);
      m_spec = ((m_spec << 1) | int'(bus.spec_taken_i)) & 255;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.flush_bp_i = 0; bus.debug_mode_i = 0; bus.spec_valid_i = 0; bus.spec_taken_i = 0;
    bus.resolve_valid_i = 0; bus.resolve_taken_i = 0; bus.resolve_mispredict_i = 0;
    bus.pipe_flush_i = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; bus.vpc_i = 64'h1A4;
    tick(); tick();
    rst = 0; #1;
    n_vec++; if (bus.ghr_o !== 8'h00) begin n_err++; $display("FAIL reset_ghr: got %h want 00", bus.ghr_o); end
    n_vec++; if (bus.index_o !== 8'hD2) begin n_err++; $display("FAIL reset_index: got %h want d2", bus.index_o); end
    n_vec++; if (bus.spec_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.spec_ready_o); end
    n_vec++; if (bus.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_upd_valid: got %b want 0", bus.upd_valid_o); end
    n_vec++; if (bus.upd_index_o !== 8'h00) begin n_err++; $display("FAIL reset_upd_index: got %h want 00", bus.upd_index_o); end
  endtask

  task automatic test_push_resolve();
    bus.vpc_i = 64'h1A4; bus.spec_valid_i = 1;
    bus.spec_taken_i = 1; tick();
    bus.spec_taken_i = 0; tick();
    bus.spec_taken_i = 1; tick();
    bus.spec_valid_i = 0; #1;
    n_vec++; if (bus.ghr_o !== 8'h05) begin n_err++; $display("FAIL push_ghr: got %h want 05", bus.ghr_o); end
    n_vec++; if (bus.index_o !== 8'hD7) begin n_err++; $display("FAIL push_index: got %h want d7", bus.index_o); end
    bus.resolve_valid_i = 1; bus.resolve_taken_i = 1; bus.resolve_mispredict_i = 0;
    tick();
    bus.resolve_valid_i = 0; #1;
    n_vec++; if (bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL resolve_upd_valid: got %b want 1", bus.upd_valid_o); end
    n_vec++; if (bus.upd_index_o !== 8'hD2) begin n_err++; $display("FAIL resolve_upd_index: got %h want d2", bus.upd_index_o); end
    n_vec++; if (bus.upd_taken_o !== 1'b1) begin n_err++; $display("FAIL resolve_upd_taken: got %b want 1", bus.upd_taken_o); end
    n_vec++; if (bus.ghr_o !== 8'h05) begin n_err++; $display("FAIL resolve_ghr_hold: got %h want 05", bus.ghr_o); end
    tick();
    n_vec++; if (bus.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL resolve_pulse: got %b want 0", bus.upd_valid_o); end
  endtask

  task automatic test_mispredict();
    bus.resolve_valid_i = 1; bus.resolve_taken_i = 1; bus.resolve_mispredict_i = 1;
    bus.spec_valid_i = 1; bus.spec_taken_i = 0;
    tick();
    idle(); #1;
    n_vec++; if (bus.ghr_o !== 8'h03) begin n_err++; $display("FAIL mispred_ghr: got %h want 03", bus.ghr_o); end
    n_vec++; if (bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL mispred_upd_valid: got %b want 1", bus.upd_valid_o); end
    n_vec++; if (bus.upd_index_o !== 8'hD3) begin n_err++; $display("FAIL mispred_upd_index: got %h want d3", bus.upd_index_o); end
    n_vec++; if (bus.upd_taken_o !== 1'b1) begin n_err++; $display("FAIL mispred_upd_taken: got %b want 1", bus.upd_taken_o); end
  endtask

  task automatic test_full();
    bus.spec_valid_i = 1;
    for (int i = 0; i < 7; i++) begin bus.spec_taken_i = 1'($urandom); tick(); end
    n_vec++; if (bus.spec_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready7: got %b want 1", bus.spec_ready_o); end
    tick();
    n_vec++; if (bus.spec_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready8: got %b want 0", bus.spec_ready_o); end
    bus.resolve_valid_i = 1; bus.resolve_taken_i = 0; bus.resolve_mispredict_i = 0;
    tick();
    bus.resolve_valid_i = 0; #1;
    n_vec++; if (bus.spec_ready_o !== 1'b1) begin n_err++; $display("FAIL full_refused_ready: got %b want 1", bus.spec_ready_o); end
    n_vec++; if (bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL full_pop_upd: got %b want 1", bus.upd_valid_o); end
    n_vec++; if (bus.ghr_o !== 8'(m_spec)) begin n_err++; $display("FAIL full_refused_ghr: got %h want %h", bus.ghr_o, 8'(m_spec)); end
    tick();
    n_vec++; if (bus.spec_ready_o !== 1'b0) begin n_err++; $display("FAIL full_next_push: got %b want 0", bus.spec_ready_o); end
    n_vec++; if (bus.ghr_o !== 8'(m_spec)) begin n_err++; $display("FAIL full_next_ghr: got %h want %h", bus.ghr_o, 8'(m_spec)); end
    idle();
  endtask

  task automatic test_flush_bp();
    bus.flush_bp_i = 1; tick(); bus.flush_bp_i = 0;
    bus.spec_valid_i = 1;
    for (int i = 0; i < 4; i++) begin bus.spec_taken_i = 1; tick(); end
    bus.spec_valid_i = 0; bus.flush_bp_i = 1; tick(); bus.flush_bp_i = 0; #1;
    n_vec++; if (bus.ghr_o !== 8'h00) begin n_err++; $display("FAIL flushbp_ghr: got %h want 00", bus.ghr_o); end
    n_vec++; if (bus.spec_ready_o !== 1'b1) begin n_err++; $display("FAIL flushbp_ready: got %b want 1", bus.spec_ready_o); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL flushbp_no_upd: got %b want 0", bus.upd_valid_o); end
      tick();
    end
    bus.spec_valid_i = 1; bus.spec_taken_i = 1; tick();
    bus.debug_mode_i = 1; tick();
    bus.debug_mode_i = 0; bus.spec_valid_i = 0; #1;
    n_vec++; if (bus.ghr_o !== 8'h01) begin n_err++; $display("FAIL debug_ghr: got %h want 01", bus.ghr_o); end
  endtask

  task automatic test_pipe_flush();
    bus.flush_bp_i = 1; tick(); bus.flush_bp_i = 0;
    bus.spec_valid_i = 1;
    bus.spec_taken_i = 1; tick(); tick();
    bus.spec_taken_i = 0; tick();
    bus.resolve_valid_i = 1; bus.resolve_taken_i = 1; bus.pipe_flush_i = 1;
    tick();
    idle(); #1;
    n_vec++; if (bus.ghr_o !== 8'h01) begin n_err++; $display("FAIL pflush_ghr: got %h want 01", bus.ghr_o); end
    n_vec++; if (bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL pflush_upd_valid: got %b want 1", bus.upd_valid_o); end
    n_vec++; if (bus.upd_taken_o !== 1'b1) begin n_err++; $display("FAIL pflush_upd_taken: got %b want 1", bus.upd_taken_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst                      = ($urandom_range(0, 199) == 0);
      bus.flush_bp_i           = ($urandom_range(0, 99) == 0);
      bus.pipe_flush_i         = ($urandom_range(0, 39) == 0);
      bus.debug_mode_i         = ($urandom_range(0, 9) == 0);
      bus.vpc_i                = {$urandom, $urandom};
      bus.spec_valid_i         = ($urandom_range(0, 2) != 0);
      bus.spec_taken_i         = 1'($urandom);
      bus.resolve_valid_i      = (m_snap.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.resolve_taken_i      = 1'($urandom);
      bus.resolve_mispredict_i = ($urandom_range(0, 5) == 0);
      #1;
      n_vec++; if (bus.ghr_o !== 8'(m_spec)) begin n_err++; $display("FAIL rnd_ghr c=%0d: got %h want %h", c, bus.ghr_o, 8'(m_spec)); end
      n_vec++; if (bus.index_o !== 8'(exp_index())) begin n_err++; $display("FAIL rnd_index c=%0d: got %h want %h", c, bus.index_o, 8'(exp_index())); end
      n_vec++; if (bus.spec_ready_o !== (m_snap.size() < NC)) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.spec_ready_o, m_snap.size() < NC); end
      n_vec++; if (bus.upd_valid_o !== m_uv) begin n_err++; $display("FAIL rnd_upd_valid c=%0d: got %b want %b", c, bus.upd_valid_o, m_uv); end
      if (m_uv) begin
        n_vec++; if (bus.upd_index_o !== 8'(m_ui)) begin n_err++; $display("FAIL rnd_upd_index c=%0d: got %h want %h", c, bus.upd_index_o, 8'(m_ui)); end
        n_vec++; if (bus.upd_taken_o !== 1'(m_ut)) begin n_err++; $display("FAIL rnd_upd_taken c=%0d: got %b want %b", c, bus.upd_taken_o, 1'(m_ut)); end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; idle(); bus.vpc_i = '0;
    test_reset();
    test_push_resolve();
    test_mispredict();
    test_full();
    test_flush_bp();
    test_pipe_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
